// File: rtl/latch_sr_ctrl_pkg.sv
// Shared types and constants for the latch S/R controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package latch_sr_ctrl_pkg;

  // State encodings. ST_GAP is used only when LATCH_SR_CTRL_DEADTIME_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET_P = 3'd1,
    ST_SET_W = 3'd2,
    ST_RUN   = 3'd3,
    ST_RST_P = 3'd4,
    ST_RST_W = 3'd5,
    ST_FAULT = 3'd6,
    ST_GAP   = 3'd7
  } state_e;

  localparam int PULSE_LEN_DEF   = 2;
  localparam int ACK_TIMEOUT_DEF = 8;
  localparam int PULSE_CNT_W     = 4;
  localparam int ACK_CNT_W       = 8;

  // States in which the reset drive to the latch is held high.
  function automatic logic drives_r(input state_e s);
    return (s == ST_RST_P) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/latch_sr_ctrl_if.sv
// Bundles panel/timer requests, latch feedback and controller drives.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels.
interface latch_sr_ctrl_if;
  logic start;
  logic stop;
  logic door_closed;
  logic timer_done;
  logic Q;
  logic S;
  logic R;
  logic mag_on;
  logic busy;
  logic fault;

  modport master (
    output start, stop, door_closed, timer_done, Q,
    input  S, R, mag_on, busy, fault
  );

  modport slave (
    input  start, stop, door_closed, timer_done, Q,
    output S, R, mag_on, busy, fault
  );
endinterface

// File: rtl/latch_sr_ctrl_pulse_timer.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
// Latency: a load takes effect on the next clock; done_o follows the register.
// Backpressure: none; a load always wins over the decrement.
module latch_sr_ctrl_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/latch_sr_ctrl.sv
// Drives latch_SR S/R with clean pulses, confirms via Q; mag_on only in RUN.
// Latency: all outputs registered, one clock after the qualifying input is sampled.
// Backpressure: none; optional S->R deadtime gap under LATCH_SR_CTRL_DEADTIME_EN.
module latch_sr_ctrl
  import latch_sr_ctrl_pkg::*;
#(
  parameter int PULSE_LEN   = PULSE_LEN_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  latch_sr_ctrl_if.slave bus
);

  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(PULSE_LEN - 1);
  localparam logic [ACK_CNT_W-1:0]   ACK_LOAD   = ACK_CNT_W'(ACK_TIMEOUT - 1);

`ifdef LATCH_SR_CTRL_DEADTIME_EN
  // An aborted S pulse passes through an all-low cycle before R rises.
  localparam state_e ABORT_TGT = ST_GAP;
`else
  localparam state_e ABORT_TGT = ST_RST_P;
`endif

  state_e state_q, state_d;
  logic   start_q;
  logic   s_q, s_d;
  logic   r_q, r_d;
  logic   mag_q, mag_d;
  logic   busy_q, busy_d;
  logic   fault_q, fault_d;
  logic   pulse_load, ack_load;
  logic   pulse_done, ack_done;
  logic   start_edge, abort;

  assign start_edge = bus.start && !start_q;
  assign abort      = !bus.door_closed || bus.stop;

  // Next state, timer loads and the output values for the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge && bus.door_closed && !bus.stop && !bus.timer_done)
                  state_d = ST_SET_P;
      ST_SET_P: if (abort)          state_d = ABORT_TGT;
                else if (pulse_done) state_d = ST_SET_W;
      ST_SET_W: if (abort)          state_d = ST_RST_P;
                else if (bus.Q)      state_d = ST_RUN;
                else if (ack_done)   state_d = ST_FAULT;
      ST_RUN:   if (abort || bus.timer_done || !bus.Q)
                  state_d = ST_RST_P;
      ST_RST_P: if (pulse_done)     state_d = ST_RST_W;
      ST_RST_W: if (!bus.Q)         state_d = ST_IDLE;
                else if (ack_done)   state_d = ST_FAULT;
      ST_FAULT: if (bus.stop && !bus.Q)
                  state_d = ST_IDLE;
      ST_GAP:   state_d = ST_RST_P;
    endcase

    pulse_load = (state_d != state_q) && ((state_d == ST_SET_P) || (state_d == ST_RST_P));
    ack_load   = (state_d != state_q) && ((state_d == ST_SET_W) || (state_d == ST_RST_W));

    s_d     = (state_d == ST_SET_P);
    r_d     = drives_r(state_d);
    mag_d   = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  // State, start-edge history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      mag_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      s_q     <= s_d;
      r_q     <= r_d;
      mag_q   <= mag_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  latch_sr_ctrl_pulse_timer #(.W(PULSE_CNT_W)) u_pulse_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (pulse_load),
    .val_i  (PULSE_LOAD),
    .done_o (pulse_done)
  );

  latch_sr_ctrl_pulse_timer #(.W(ACK_CNT_W)) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (ack_load),
    .val_i  (ACK_LOAD),
    .done_o (ack_done)
  );

  assign bus.S      = s_q;
  assign bus.R      = r_q;
  assign bus.mag_on = mag_q;
  assign bus.busy   = busy_q;
  assign bus.fault  = fault_q;

endmodule

// File: tb/tb_latch_sr_ctrl.sv
// Bench for latch_sr_ctrl with a behavioural latch_SR and a cycle scoreboard.
// Latency: expected outputs are queued at each rising edge and compared at the falling edge.
// Backpressure: none; honours LATCH_SR_CTRL_DEADTIME_EN in the reference model.
module tb_latch_sr_ctrl;

  localparam int PL = 2;
  localparam int AT = 8;

  typedef enum int {M_IDLE, M_SETTING, M_WAIT_ON, M_ON, M_CLEARING, M_WAIT_OFF, M_FAULT, M_GAP} mode_e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   stuck = 0;          // 0 = healthy latch, 1 = Q stuck low, 2 = Q stuck high
  int   n_checks = 0;
  int   n_fail = 0;

  latch_sr_ctrl_if bus();

  latch_sr_ctrl #(.PULSE_LEN(PL), .ACK_TIMEOUT(AT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural latch_SR with optional stuck-at fault injection.
  always @(posedge clk or posedge rst) begin
    if (rst)             bus.Q <= 1'b0;
    else if (stuck == 1) bus.Q <= 1'b0;
    else if (stuck == 2) bus.Q <= 1'b1;
    else if (bus.S)      bus.Q <= 1'b1;
    else if (bus.R)      bus.Q <= 1'b0;
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: what the controller should be doing after each edge.
  mode_e      m_mode = M_IDLE;
  int         m_left = 0;
  logic       m_prev_start = 1'b0;
  logic       m_edge, m_abort;
  logic [4:0] exp_q[$];

  // Advance the model at each edge and queue the outputs it implies.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_left = 0;
      m_prev_start = 1'b0;
    end else begin
      m_edge = bus.start && !m_prev_start;
      m_prev_start = bus.start;
      m_abort = !bus.door_closed || bus.stop;
      case (m_mode)
        M_IDLE:
          if (m_edge && bus.door_closed && !bus.stop && !bus.timer_done) begin
            m_mode = M_SETTING; m_left = PL;
          end
        M_SETTING:
          if (m_abort) begin
`ifdef LATCH_SR_CTRL_DEADTIME_EN
            m_mode = M_GAP;
`else
            m_mode = M_CLEARING; m_left = PL;
`endif
          end else begin
            m_left--;
            if (m_left == 0) begin m_mode = M_WAIT_ON; m_left = AT; end
          end
        M_WAIT_ON:
          if (m_abort) begin m_mode = M_CLEARING; m_left = PL; end
          else if (bus.Q) m_mode = M_ON;
          else begin
            m_left--;
            if (m_left == 0) m_mode = M_FAULT;
          end
        M_ON:
          if (m_abort || bus.timer_done || !bus.Q) begin m_mode = M_CLEARING; m_left = PL; end
        M_CLEARING: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_WAIT_OFF; m_left = AT; end
        end
        M_WAIT_OFF:
          if (!bus.Q) m_mode = M_IDLE;
          else begin
            m_left--;
            if (m_left == 0) m_mode = M_FAULT;
          end
        M_FAULT:
          if (bus.stop && !bus.Q) m_mode = M_IDLE;
        M_GAP: begin m_mode = M_CLEARING; m_left = PL; end
      endcase
    end
    exp_q.push_back({m_mode == M_SETTING,
                     (m_mode == M_CLEARING) || (m_mode == M_FAULT),
                     m_mode == M_ON,
                     (m_mode != M_IDLE) && (m_mode != M_ON),
                     m_mode == M_FAULT});
  end

  logic [4:0] mon_e;

  // Compare DUT outputs against the queued expectation, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (rst) mon_e = 5'b0;
      check("outputs{S,R,mag_on,busy,fault}", {bus.S, bus.R, bus.mag_on, bus.busy, bus.fault}, mon_e);
    end
    check("S_and_R_exclusive", {4'b0, bus.S && bus.R}, 5'b0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int w);
    case (w)
      0:       return bus.mag_on;
      1:       return bus.busy;
      default: return bus.fault;
    endcase
  endfunction

  // Bounded wait for an output to reach a value; expiry counts as a failure.
  task automatic wait_sig(input int w, input logic val, input int budget, input string name);
    int n = 0;
    while (get_sig(w) !== val && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, {4'b0, get_sig(w)}, {4'b0, val});
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_closed = 1'b1; bus.timer_done = 1'b0;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Normal start: S pulse, latch sets, RUN with busy low.
    bus.start = 1'b1;
    wait_sig(0, 1'b1, 4, "start_to_mag_on");
    check("busy_in_run", {4'b0, bus.busy}, 5'b0);
    bus.start = 1'b0;
    cyc(3);

    // Timer expiry: mag_on drops at once, reset pulse, back to IDLE.
    bus.timer_done = 1'b1;
    cyc(1);
    bus.timer_done = 1'b0;
    wait_sig(0, 1'b0, 1, "timer_done_mag_off");
    wait_sig(1, 1'b0, 10, "timer_done_to_idle");
    check("q_after_clear", {4'b0, bus.Q}, 5'b0);

    // Door opens during the S pulse.
    bus.start = 1'b1;
    cyc(1);
    bus.door_closed = 1'b0;
    cyc(1);
    bus.door_closed = 1'b1;
    bus.start = 1'b0;
    wait_sig(1, 1'b0, 15, "door_abort_to_idle");
    check("q_after_abort", {4'b0, bus.Q}, 5'b0);

    // Latch never acknowledges: fault after pulse plus timeout, stop clears it.
    stuck = 1;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    wait_sig(2, 1'b1, 12, "stuck_q_fault");
    check("r_held_in_fault", {4'b0, bus.R}, 5'b00001);
    bus.stop = 1'b1;
    wait_sig(1, 1'b0, 3, "stop_clears_fault");
    check("fault_cleared", {4'b0, bus.fault}, 5'b0);
    bus.stop = 1'b0;
    stuck = 0;
    cyc(2);

    // Start edge with stop high, then with the door open: discarded.
    bus.stop = 1'b1;
    bus.start = 1'b1;
    cyc(20);
    check("start_with_stop_idle", {4'b0, bus.busy}, 5'b0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.door_closed = 1'b0;
    cyc(1);
    bus.start = 1'b1;
    cyc(20);
    check("start_door_open_idle", {4'b0, bus.busy}, 5'b0);
    bus.start = 1'b0;
    bus.door_closed = 1'b1;
    cyc(2);

    // Reset in the middle of the S pulse clears S without a clock.
    bus.start = 1'b1;
    cyc(1);
    check("s_before_rst", {4'b0, bus.S}, 5'b00001);
    #2 rst = 1'b1;
    #1 check("s_async_rst", {4'b0, bus.S}, 5'b0);
    cyc(2);
    rst = 1'b0;
    bus.start = 1'b0;
    cyc(2);

    // Randomised traffic, including latch stuck faults.
    for (int i = 0; i < 3000; i++) begin
      bus.start       = 1'($urandom_range(0, 1));
      bus.stop        = ($urandom_range(0, 19) == 0);
      bus.door_closed = ($urandom_range(0, 15) != 0);
      bus.timer_done  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) stuck = ($urandom_range(0, 3) == 0) ? 2 : (($urandom_range(0, 1) == 0) ? 1 : 0);
      cyc(1);
    end

    // Drain to IDLE.
    stuck = 0;
    bus.start = 1'b0;
    bus.timer_done = 1'b0;
    bus.stop = 1'b1;
    wait_sig(1, 1'b0, 40, "drain_to_idle");
    bus.stop = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
